// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM between two clients; write and read ports arbitrate independently.
// Optional `define DPRAM_ARB_WR_FWD_EN forwards same-cycle write data to a colliding read on return.
module dpram_port_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c0_wr_req,
  input  logic [AW-1:0] c0_wr_addr,
  input  logic [DW-1:0] c0_wr_data,
  output logic          c0_wr_gnt,
  input  logic          c0_rd_req,
  input  logic [AW-1:0] c0_rd_addr,
  output logic          c0_rd_gnt,
  output logic          c0_rd_valid,
  output logic [DW-1:0] c0_rd_data,
  input  logic          c1_wr_req,
  input  logic [AW-1:0] c1_wr_addr,
  input  logic [DW-1:0] c1_wr_data,
  output logic          c1_wr_gnt,
  input  logic          c1_rd_req,
  input  logic [AW-1:0] c1_rd_addr,
  output logic          c1_rd_gnt,
  output logic          c1_rd_valid,
  output logic [DW-1:0] c1_rd_data,
  output logic          ram_wr_en,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] ram_data_in,
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_data_out
);

  logic          wr_last_q, rd_last_q;
  logic          ram_wr_en_q, ram_rd_en_q;
  logic [AW-1:0] ram_wr_addr_q, ram_rd_addr_q;
  logic [DW-1:0] ram_data_in_q;
  logic [RD_LAT:0] vld_pipe_q, id_pipe_q;

  logic          wr_any_d, rd_any_d;
  logic [AW-1:0] wr_addr_d, rd_addr_d;
  logic [DW-1:0] wr_data_d, ret_data;

  // The client that did not win last time gets priority when both ask.
  always_comb begin
    c0_wr_gnt = !rst && c0_wr_req && (!c1_wr_req ||  wr_last_q);
    c1_wr_gnt = !rst && c1_wr_req && (!c0_wr_req || !wr_last_q);
    c0_rd_gnt = !rst && c0_rd_req && (!c1_rd_req ||  rd_last_q);
    c1_rd_gnt = !rst && c1_rd_req && (!c0_rd_req || !rd_last_q);
    wr_any_d  = c0_wr_gnt || c1_wr_gnt;
    rd_any_d  = c0_rd_gnt || c1_rd_gnt;
    wr_addr_d = c1_wr_gnt ? c1_wr_addr : c0_wr_addr;
    wr_data_d = c1_wr_gnt ? c1_wr_data : c0_wr_data;
    rd_addr_d = c1_rd_gnt ? c1_rd_addr : c0_rd_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_last_q     <= 1'b1;
      rd_last_q     <= 1'b1;
      ram_wr_en_q   <= 1'b0;
      ram_rd_en_q   <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_rd_addr_q <= '0;
      ram_data_in_q <= '0;
      vld_pipe_q    <= '0;
      id_pipe_q     <= '0;
    end else begin
      ram_wr_en_q <= wr_any_d;
      ram_rd_en_q <= rd_any_d;
      if (wr_any_d) begin
        wr_last_q     <= c1_wr_gnt;
        ram_wr_addr_q <= wr_addr_d;
        ram_data_in_q <= wr_data_d;
      end
      if (rd_any_d) begin
        rd_last_q     <= c1_rd_gnt;
        ram_rd_addr_q <= rd_addr_d;
      end
      // Stage 0 lines up with the RAM issue cycle, stage RD_LAT with the data return.
      vld_pipe_q <= {vld_pipe_q[RD_LAT-1:0], rd_any_d};
      id_pipe_q  <= {id_pipe_q[RD_LAT-1:0],  c1_rd_gnt};
    end
  end

`ifdef DPRAM_ARB_WR_FWD_EN
  logic [RD_LAT:1]         fwd_q;
  logic [RD_LAT:1][DW-1:0] fwd_data_q;
  logic                    coll;

  assign coll = ram_wr_en_q && ram_rd_en_q && (ram_wr_addr_q == ram_rd_addr_q);

  always_ff @(posedge clk) begin
    if (rst) fwd_q <= '0;
    else begin
      fwd_q[1] <= coll;
      for (int k = 2; k <= RD_LAT; k++) fwd_q[k] <= fwd_q[k-1];
    end
    fwd_data_q[1] <= ram_data_in_q;
    for (int k = 2; k <= RD_LAT; k++) fwd_data_q[k] <= fwd_data_q[k-1];
  end

  assign ret_data = fwd_q[RD_LAT] ? fwd_data_q[RD_LAT] : ram_data_out;
`else
  assign ret_data = ram_data_out;
`endif

  assign ram_wr_en   = ram_wr_en_q;
  assign ram_wr_addr = ram_wr_addr_q;
  assign ram_data_in = ram_data_in_q;
  assign ram_rd_en   = ram_rd_en_q;
  assign ram_rd_addr = ram_rd_addr_q;
  assign c0_rd_valid = vld_pipe_q[RD_LAT] && !id_pipe_q[RD_LAT];
  assign c1_rd_valid = vld_pipe_q[RD_LAT] &&  id_pipe_q[RD_LAT];
  assign c0_rd_data  = ret_data;
  assign c1_rd_data  = ret_data;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: instance 0 at RD_LAT=1, instance 1 at RD_LAT=3, each with a read-before-write RAM model.
module tb_dpram_port_arbiter;

  typedef struct packed {
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [7:0] rd_addr;
  } cli_in_t;

  typedef struct {
    logic [1:0] wreq;
    logic [1:0] rreq;
    logic [1:0] ewg;
    logic [1:0] erg;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  cli_in_t [1:0][1:0]      cin;
  logic [1:0][1:0]         wr_gnt, rd_gnt, rd_valid;
  logic [1:0][1:0][7:0]    rd_data;
  logic [1:0]              ram_wr_en, ram_rd_en;
  logic [1:0][7:0]         ram_wr_addr, ram_data_in, ram_rd_addr, ram_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [7:0] mem  [256];
    logic [7:0] pipe [LAT];

    dpram_port_arbiter #(.AW(8), .DW(8), .RD_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .c0_wr_req(cin[g][0].wr_req), .c0_wr_addr(cin[g][0].wr_addr), .c0_wr_data(cin[g][0].wr_data),
      .c0_wr_gnt(wr_gnt[g][0]),
      .c0_rd_req(cin[g][0].rd_req), .c0_rd_addr(cin[g][0].rd_addr), .c0_rd_gnt(rd_gnt[g][0]),
      .c0_rd_valid(rd_valid[g][0]), .c0_rd_data(rd_data[g][0]),
      .c1_wr_req(cin[g][1].wr_req), .c1_wr_addr(cin[g][1].wr_addr), .c1_wr_data(cin[g][1].wr_data),
      .c1_wr_gnt(wr_gnt[g][1]),
      .c1_rd_req(cin[g][1].rd_req), .c1_rd_addr(cin[g][1].rd_addr), .c1_rd_gnt(rd_gnt[g][1]),
      .c1_rd_valid(rd_valid[g][1]), .c1_rd_data(rd_data[g][1]),
      .ram_wr_en(ram_wr_en[g]), .ram_wr_addr(ram_wr_addr[g]), .ram_data_in(ram_data_in[g]),
      .ram_rd_en(ram_rd_en[g]), .ram_rd_addr(ram_rd_addr[g]), .ram_data_out(ram_data_out[g])
    );

    initial begin
      for (int k = 0; k < 256; k++) mem[k] = 8'h00;
      for (int k = 0; k < LAT; k++) pipe[k] = 8'h00;
    end

    // Nonblocking read and write in the same edge give read-before-write.
    always @(posedge clk) begin
      if (ram_rd_en[g]) pipe[0] <= mem[ram_rd_addr[g]];
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      if (ram_wr_en[g]) mem[ram_wr_addr[g]] <= ram_data_in[g];
    end
    assign ram_data_out[g] = pipe[LAT-1];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [12];
    logic [7:0] exp_wa, exp_wd, exp_ra;
    logic       exp_we, exp_re;
    logic [1:0] exp_rv;
    logic [7:0] exp_coll;

    tbl[0]  = '{2'b11, 2'b11, 2'b01, 2'b01};
    tbl[1]  = '{2'b11, 2'b11, 2'b10, 2'b10};
    tbl[2]  = '{2'b11, 2'b11, 2'b01, 2'b01};
    tbl[3]  = '{2'b11, 2'b11, 2'b10, 2'b10};
    tbl[4]  = '{2'b11, 2'b11, 2'b01, 2'b01};
    tbl[5]  = '{2'b11, 2'b11, 2'b10, 2'b10};
    tbl[6]  = '{2'b10, 2'b10, 2'b10, 2'b10};
    tbl[7]  = '{2'b11, 2'b01, 2'b01, 2'b01};
    tbl[8]  = '{2'b01, 2'b11, 2'b01, 2'b10};
    tbl[9]  = '{2'b11, 2'b00, 2'b10, 2'b00};
    tbl[10] = '{2'b00, 2'b00, 2'b00, 2'b00};
    tbl[11] = '{2'b00, 2'b00, 2'b00, 2'b00};

    // Reset with requests pending: grants must stay low.
    cin = '0;
    rst = 1'b1;
    next();
    cin[0][0].wr_req = 1'b1; cin[0][1].wr_req = 1'b1;
    cin[0][0].rd_req = 1'b1; cin[0][1].rd_req = 1'b1;
    mid();
    chk("gnt_in_reset", {wr_gnt[0], rd_gnt[0]}, 4'b0000);
    next();
    cin = '0;
    next();
    rst = 1'b0;

    for (int c = 0; c < 10; c++) begin
      mid();
      chk($sformatf("idle_%0d", c),
          {ram_wr_en[0], ram_rd_en[0], ram_wr_addr[0], ram_data_in[0], ram_rd_addr[0],
           wr_gnt[0], rd_gnt[0], rd_valid[0]}, 32'h0);
      next();
    end

    // Table: arbitration sequence from reset pointers, includes 6 cycles of contention.
    exp_wa = 8'h00; exp_wd = 8'h00; exp_ra = 8'h00; exp_we = 1'b0; exp_re = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cin[0][0].wr_req  = tbl[i].wreq[0];
      cin[0][1].wr_req  = tbl[i].wreq[1];
      cin[0][0].rd_req  = tbl[i].rreq[0];
      cin[0][1].rd_req  = tbl[i].rreq[1];
      cin[0][0].wr_addr = 8'h80 + 8'(i);
      cin[0][0].wr_data = 8'h10 + 8'(i);
      cin[0][1].wr_addr = 8'hC0 + 8'(i);
      cin[0][1].wr_data = 8'h20 + 8'(i);
      cin[0][0].rd_addr = 8'h50 + 8'(i);
      cin[0][1].rd_addr = 8'h60 + 8'(i);
      exp_rv = (i >= 2) ? tbl[i-2].erg : 2'b00;
      mid();
      chk($sformatf("tbl%0d_wr_gnt", i), wr_gnt[0], tbl[i].ewg);
      chk($sformatf("tbl%0d_rd_gnt", i), rd_gnt[0], tbl[i].erg);
      chk($sformatf("tbl%0d_ram_wr", i), {ram_wr_en[0], ram_wr_addr[0], ram_data_in[0]},
          {exp_we, exp_wa, exp_wd});
      chk($sformatf("tbl%0d_ram_rd", i), {ram_rd_en[0], ram_rd_addr[0]}, {exp_re, exp_ra});
      chk($sformatf("tbl%0d_rd_valid", i), rd_valid[0], exp_rv);
      exp_we = |tbl[i].ewg;
      exp_re = |tbl[i].erg;
      if (tbl[i].ewg[1])      begin exp_wa = 8'hC0 + 8'(i); exp_wd = 8'h20 + 8'(i); end
      else if (tbl[i].ewg[0]) begin exp_wa = 8'h80 + 8'(i); exp_wd = 8'h10 + 8'(i); end
      if (tbl[i].erg[1])      exp_ra = 8'h60 + 8'(i);
      else if (tbl[i].erg[0]) exp_ra = 8'h50 + 8'(i);
      next();
    end
    cin = '0;

    // c0 writes 0x10=A5, then c1 reads it back.
    next();
    cin[0][0].wr_req = 1'b1; cin[0][0].wr_addr = 8'h10; cin[0][0].wr_data = 8'hA5;
    mid(); chk("wr10_gnt", wr_gnt[0], 2'b01);
    next(); cin = '0;
    next();
    cin[0][1].rd_req = 1'b1; cin[0][1].rd_addr = 8'h10;
    mid(); chk("rd10_gnt", rd_gnt[0], 2'b10);
    next(); cin = '0;
    mid(); chk("rd10_issue", {ram_rd_en[0], ram_rd_addr[0]}, {1'b1, 8'h10});
    next();
    mid(); chk("rd10_valid", rd_valid[0], 2'b10);
    chk("rd10_data", rd_data[0][1], 8'hA5);
    next();
    mid(); chk("rd10_valid_off", rd_valid[0], 2'b00);

    // Same-address read and write in one cycle.
    next();
    cin[0][0].wr_req = 1'b1; cin[0][0].wr_addr = 8'h20; cin[0][0].wr_data = 8'h11;
    next(); cin = '0;
    next();
    cin[0][0].rd_req = 1'b1; cin[0][0].rd_addr = 8'h20;
    cin[0][1].wr_req = 1'b1; cin[0][1].wr_addr = 8'h20; cin[0][1].wr_data = 8'h3C;
    mid();
    chk("coll_gnts", {wr_gnt[0], rd_gnt[0]}, 4'b1001);
    next(); cin = '0;
    mid();
    chk("coll_issue", {ram_wr_en[0], ram_rd_en[0], ram_wr_addr[0], ram_rd_addr[0]},
        {2'b11, 8'h20, 8'h20});
    next();
`ifdef DPRAM_ARB_WR_FWD_EN
    exp_coll = 8'h3C;
`else
    exp_coll = 8'h11;
`endif
    mid();
    chk("coll_valid", rd_valid[0], 2'b01);
    chk("coll_data", rd_data[0][0], exp_coll);

    // Reset while a read is in flight; pointers left at 0 beforehand.
    next();
    cin[0][0].wr_req = 1'b1; cin[0][0].wr_addr = 8'h30; cin[0][0].wr_data = 8'h77;
    cin[0][0].rd_req = 1'b1; cin[0][0].rd_addr = 8'h10;
    mid(); chk("flight_gnts", {wr_gnt[0], rd_gnt[0]}, 4'b0101);
    next(); cin = '0; rst = 1'b1;
    mid(); chk("flight_issue", ram_rd_en[0], 1'b1);
    next(); rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mid(); chk($sformatf("flight_no_valid_%0d", c), rd_valid[0], 2'b00);
      next();
    end
    cin[0][0].wr_req = 1'b1; cin[0][1].wr_req = 1'b1;
    cin[0][0].rd_req = 1'b1; cin[0][1].rd_req = 1'b1;
    mid(); chk("post_rst_contend", {wr_gnt[0], rd_gnt[0]}, 4'b0101);
    next(); cin = '0;
    next(); next(); next();

    // RD_LAT=3 instance: preload 0..3, then c1 streams 4 reads.
    for (int a = 0; a < 4; a++) begin
      cin[1][0].wr_req = 1'b1; cin[1][0].wr_addr = 8'(a); cin[1][0].wr_data = 8'h40 + 8'(a);
      mid(); chk($sformatf("lat3_wr%0d_gnt", a), wr_gnt[1], 2'b01);
      next();
    end
    cin = '0;
    next();
    for (int j = 0; j < 10; j++) begin
      cin[1][1].rd_req  = (j < 4);
      cin[1][1].rd_addr = 8'(j);
      mid();
      if (j < 4) chk($sformatf("lat3_rd%0d_gnt", j), rd_gnt[1], 2'b10);
      chk($sformatf("lat3_valid_%0d", j), rd_valid[1], (j >= 4 && j < 8) ? 2'b10 : 2'b00);
      if (j >= 4 && j < 8)
        chk($sformatf("lat3_data_%0d", j), rd_data[1][1], 8'h40 + 8'(j - 4));
      next();
    end
    cin = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
